// File: rtl/axi_write_master.sv
// axi_write_master
// AXI4 write-channel initiator. Takes a (start address, byte count) request
// plus a stream of 512-bit data beats and pushes them out as INCR bursts of
// up to 64 beats (4 KB each), one burst in flight at a time. B responses are
// folded into a sticky error flag and one completion is returned per request.
//
// Ports:
//   core_clk, rst               clock, asynchronous active-high reset
//   write_req_*                 request handshake, start address, byte count
//   write_data_*                512-bit data beat stream from the producer
//   write_resp_*                completion handshake and aggregated error
//   axi_aw*, axi_w*, axi_b*     AXI4 write address / data / response channels
module axi_write_master #(
   parameter int MAX_BYTE_COUNT    = 1000000000,
   parameter int AXI_ADDRESS_WIDTH = 34,
   parameter int DATA_WIDTH        = 512,
   parameter int BC_W              = $clog2(MAX_BYTE_COUNT)
) (
   input  logic                         core_clk,
   input  logic                         rst,
   input  logic                         write_req_valid,
   output logic                         write_req_ready,
   input  logic [AXI_ADDRESS_WIDTH-1:0] write_start_address,
   input  logic [BC_W-1:0]              write_byte_count,
   input  logic                         write_data_valid,
   output logic                         write_data_ready,
   input  logic [DATA_WIDTH-1:0]        write_data,
   output logic                         write_resp_valid,
   input  logic                         write_resp_ready,
   output logic                         write_resp_error,
   output logic [AXI_ADDRESS_WIDTH-1:0] axi_awaddr,
   output logic [1:0]                   axi_awburst,
   output logic [3:0]                   axi_awcache,
   output logic [3:0]                   axi_awid,
   output logic [7:0]                   axi_awlen,
   output logic                         axi_awlock,
   output logic [2:0]                   axi_awprot,
   output logic [3:0]                   axi_awqos,
   output logic [2:0]                   axi_awsize,
   output logic                         axi_awvalid,
   input  logic                         axi_awready,
   output logic [DATA_WIDTH-1:0]        axi_wdata,
   output logic [DATA_WIDTH/8-1:0]      axi_wstrb,
   output logic                         axi_wlast,
   output logic                         axi_wvalid,
   input  logic                         axi_wready,
   input  logic [3:0]                   axi_bid,
   input  logic [1:0]                   axi_bresp,
   input  logic                         axi_bvalid,
   output logic                         axi_bready
);

   localparam int STRB_W           = DATA_WIDTH / 8;
   localparam int BT_W             = BC_W - 5;  // wide enough for ceil(count/64)
   localparam int MAX_BEATS        = (MAX_BYTE_COUNT + 63) / 64;
   localparam int MAX_TRANSACTIONS = (MAX_BEATS + 63) / 64;
   localparam int BURST_W          = $clog2(MAX_TRANSACTIONS) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AW,
      S_W,
      S_B,
      S_RESP
   } state_t;

   state_t state, next_state;

   logic [AXI_ADDRESS_WIDTH-1:0] addr;
   logic [BURST_W-1:0]           burst_idx;
   logic [BURST_W-1:0]           burst_last;  // index of the final burst
   logic [5:0]                   last_len;    // awlen of the final burst
   logic [5:0]                   tail;        // valid bytes in the final beat, 0 = all
   logic [7:0]                   beat;
   logic                         err;

   logic [BT_W-1:0]   req_beats;
   logic [BT_W-1:0]   req_beats_m1;
   logic              req_fire;
   logic              w_fire;
   logic              is_last_burst;
   logic [7:0]        cur_len;
   logic              cur_last_beat;
   logic [STRB_W-1:0] tail_strb;

   // axi_bid carries no information: every burst is issued with ID 0.
   logic unused_bid;
   assign unused_bid = ^axi_bid;

   assign req_fire = write_req_valid && (state == S_IDLE);
   assign w_fire   = (state == S_W) && write_data_valid && axi_wready;

   assign req_beats    = BT_W'(write_byte_count[BC_W-1:6]) + BT_W'(|write_byte_count[5:0]);
   // (beats - 1) mod 64 is the final burst's awlen, covering the "0 means 64" case.
   assign req_beats_m1 = req_beats - BT_W'(1);

   assign is_last_burst = (burst_idx == burst_last);
   assign cur_len       = is_last_burst ? {2'b00, last_len} : 8'd63;
   assign cur_last_beat = (beat == cur_len);
   assign tail_strb     = ~({STRB_W{1'b1}} << tail);

   // State register
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // Next-state logic
   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: if (write_req_valid)
                    next_state = (write_byte_count == '0) ? S_RESP : S_AW;
         S_AW:   if (axi_awready) next_state = S_W;
         S_W:    if (w_fire && cur_last_beat) next_state = S_B;
         S_B:    if (axi_bvalid) next_state = is_last_burst ? S_RESP : S_AW;
         S_RESP: if (write_resp_ready) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      write_req_ready  = 1'b0;
      write_data_ready = 1'b0;
      write_resp_valid = 1'b0;
      write_resp_error = 1'b0;
      axi_awaddr       = addr;
      axi_awburst      = 2'b01;
      axi_awcache      = 4'd0;
      axi_awid         = 4'd0;
      axi_awlen        = cur_len;
      axi_awlock       = 1'b0;
      axi_awprot       = 3'd0;
      axi_awqos        = 4'd0;
      axi_awsize       = 3'b110;
      axi_awvalid      = 1'b0;
      axi_wdata        = write_data;
      axi_wstrb        = '0;
      axi_wlast        = 1'b0;
      axi_wvalid       = 1'b0;
      axi_bready       = 1'b0;
      case (state)
         S_IDLE: write_req_ready = 1'b1;
         S_AW:   axi_awvalid = 1'b1;
         S_W: begin
            // Pure pass-through: the producer talks to the W channel directly.
            axi_wvalid       = write_data_valid;
            write_data_ready = axi_wready;
            axi_wlast        = cur_last_beat;
            axi_wstrb        = (is_last_burst && cur_last_beat && tail != 6'd0)
                               ? tail_strb : {STRB_W{1'b1}};
         end
         S_B:    axi_bready = 1'b1;
         S_RESP: begin
            write_resp_valid = 1'b1;
            write_resp_error = err;
         end
         default: ;
      endcase
   end

   // Request bookkeeping, beat/burst counters, address and error flag
   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         addr       <= '0;
         burst_idx  <= '0;
         burst_last <= '0;
         last_len   <= '0;
         tail       <= '0;
         beat       <= '0;
         err        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (req_fire) begin
               addr       <= write_start_address;
               burst_idx  <= '0;
               burst_last <= BURST_W'(req_beats_m1 >> 6);
               last_len   <= req_beats_m1[5:0];
               tail       <= write_byte_count[5:0];
               beat       <= '0;
               err        <= 1'b0;
            end
            S_AW: if (axi_awready) beat <= '0;
            S_W:  if (w_fire) beat <= beat + 8'd1;
            S_B:  if (axi_bvalid) begin
               err       <= err | (axi_bresp != 2'b00);
               addr      <= addr + AXI_ADDRESS_WIDTH'(4096);
               burst_idx <= burst_idx + BURST_W'(1);
            end
            S_RESP: if (write_resp_ready) begin
               addr       <= '0;
               burst_idx  <= '0;
               burst_last <= '0;
               last_len   <= '0;
               tail       <= '0;
               beat       <= '0;
               err        <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_write_master.sv
// tb_axi_write_master
// Directed bench for axi_write_master. The bench plays producer, AXI slave
// and completion consumer in lock-step: inputs change just after each falling
// edge, outputs are compared 1 ns later, handshakes happen on the rising edge.
module tb_axi_write_master;

   localparam int AW_W = 34;
   localparam int DW   = 512;
   localparam int BC_W = 30;
   localparam logic [63:0] ALL = {64{1'b1}};

   logic            core_clk = 1'b0;
   logic            rst;
   logic            write_req_valid;
   logic            write_req_ready;
   logic [AW_W-1:0] write_start_address;
   logic [BC_W-1:0] write_byte_count;
   logic            write_data_valid;
   logic            write_data_ready;
   logic [DW-1:0]   write_data;
   logic            write_resp_valid;
   logic            write_resp_ready;
   logic            write_resp_error;
   logic [AW_W-1:0] axi_awaddr;
   logic [1:0]      axi_awburst;
   logic [3:0]      axi_awcache;
   logic [3:0]      axi_awid;
   logic [7:0]      axi_awlen;
   logic            axi_awlock;
   logic [2:0]      axi_awprot;
   logic [3:0]      axi_awqos;
   logic [2:0]      axi_awsize;
   logic            axi_awvalid;
   logic            axi_awready;
   logic [DW-1:0]   axi_wdata;
   logic [DW/8-1:0] axi_wstrb;
   logic            axi_wlast;
   logic            axi_wvalid;
   logic            axi_wready;
   logic [3:0]      axi_bid;
   logic [1:0]      axi_bresp;
   logic            axi_bvalid;
   logic            axi_bready;

   int passed   = 0;
   int total    = 0;
   int hs_count = 0;

   axi_write_master dut (
      .core_clk(core_clk), .rst(rst),
      .write_req_valid(write_req_valid), .write_req_ready(write_req_ready),
      .write_start_address(write_start_address), .write_byte_count(write_byte_count),
      .write_data_valid(write_data_valid), .write_data_ready(write_data_ready),
      .write_data(write_data),
      .write_resp_valid(write_resp_valid), .write_resp_ready(write_resp_ready),
      .write_resp_error(write_resp_error),
      .axi_awaddr(axi_awaddr), .axi_awburst(axi_awburst), .axi_awcache(axi_awcache),
      .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awlock(axi_awlock),
      .axi_awprot(axi_awprot), .axi_awqos(axi_awqos), .axi_awsize(axi_awsize),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
      .axi_bready(axi_bready)
   );

   always #5 core_clk = ~core_clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: run did not finish, passed=%0d total=%0d", passed, total);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [DW-1:0] pat(input int i);
      logic [31:0] w;
      w = 32'hA5A50000 ^ 32'(i);
      return {16{w}};
   endfunction

   task automatic sample_hs();
      if (axi_wvalid === 1'b1 && write_data_ready === 1'b1) hs_count++;
   endtask

   task automatic send_req(input logic [AW_W-1:0] a, input logic [BC_W-1:0] c);
      @(negedge core_clk);
      write_req_valid     = 1'b1;
      write_start_address = a;
      write_byte_count    = c;
      #1 check("req_ready", write_req_ready, 1'b1);
   endtask

   // AW phase with awready held low for `stall` cycles; address/len must stay put.
   task automatic aw_phase(input logic [AW_W-1:0] a, input logic [7:0] len, input int stall);
      for (int s = 0; s <= stall; s++) begin
         @(negedge core_clk);
         write_req_valid  = 1'b0;
         axi_bvalid       = 1'b0;
         axi_wready       = 1'b1;
         write_data_valid = 1'b1;
         axi_awready      = (s == stall);
         #1;
         check("awvalid", axi_awvalid, 1'b1);
         check("awaddr", axi_awaddr, a);
         check("awlen", axi_awlen, len);
         check("w_before_aw", axi_wvalid, 1'b0);
         check("dready_in_aw", write_data_ready, 1'b0);
         if (s == 0) begin
            check("awsize", axi_awsize, 3'b110);
            check("awburst", axi_awburst, 2'b01);
            check("awid", axi_awid, 4'd0);
            check("req_ready_busy", write_req_ready, 1'b0);
         end
      end
   endtask

   // W phase: n beats of a burst of length len+1, first beat index `base`.
   task automatic w_phase(input int len, input int n, input int base,
                          input logic [63:0] fstrb, input bit stall);
      for (int i = 0; i < n; i++) begin
         int nst;
         nst = stall ? int'($urandom_range(0, 2)) : 0;
         for (int s = 0; s < nst; s++) begin
            @(negedge core_clk);
            axi_awready = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
               write_data_valid = 1'b0;
               axi_wready       = 1'b1;
               #1 check("wvalid_nodata", axi_wvalid, 1'b0);
            end else begin
               write_data_valid = 1'b1;
               write_data       = pat(base + i);
               axi_wready       = 1'b0;
               #1;
               check("wvalid_stall", axi_wvalid, 1'b1);
               check("dready_stall", write_data_ready, 1'b0);
               check("wdata_stall", axi_wdata, pat(base + i));
               check("wlast_stall", axi_wlast, i == len);
            end
            sample_hs();
         end
         @(negedge core_clk);
         axi_awready      = 1'b0;
         write_data_valid = 1'b1;
         write_data       = pat(base + i);
         axi_wready       = 1'b1;
         #1;
         check("wvalid", axi_wvalid, 1'b1);
         check("dready", write_data_ready, 1'b1);
         check("wdata", axi_wdata, pat(base + i));
         check("wlast", axi_wlast, i == len);
         check("wstrb", axi_wstrb, (i == len) ? fstrb : ALL);
         sample_hs();
      end
   endtask

   task automatic b_phase(input logic [1:0] resp, input int stall);
      for (int s = 0; s <= stall; s++) begin
         @(negedge core_clk);
         write_data_valid = 1'b1;
         axi_wready       = 1'b1;
         axi_bvalid       = (s == stall);
         axi_bresp        = resp;
         #1;
         check("bready", axi_bready, 1'b1);
         check("wvalid_in_b", axi_wvalid, 1'b0);
         check("awvalid_in_b", axi_awvalid, 1'b0);
         sample_hs();
      end
   endtask

   // Completion held for one cycle before acceptance; an extra producer beat
   // offered meanwhile must not be taken.
   task automatic resp_phase(input logic err);
      @(negedge core_clk);
      write_req_valid  = 1'b0;
      axi_bvalid       = 1'b0;
      axi_awready      = 1'b1;
      write_data_valid = 1'b1;
      axi_wready       = 1'b1;
      write_resp_ready = 1'b0;
      #1;
      check("resp_valid", write_resp_valid, 1'b1);
      check("resp_error", write_resp_error, err);
      check("extra_beat_ready", write_data_ready, 1'b0);
      check("awvalid_in_resp", axi_awvalid, 1'b0);
      @(negedge core_clk);
      write_resp_ready = 1'b1;
      #1;
      check("resp_hold", write_resp_valid, 1'b1);
      check("resp_err_hold", write_resp_error, err);
      @(negedge core_clk);
      write_resp_ready = 1'b0;
      write_data_valid = 1'b0;
      axi_awready      = 1'b0;
      #1;
      check("resp_done", write_resp_valid, 1'b0);
      check("idle_ready", write_req_ready, 1'b1);
   endtask

   initial begin
      int hs0;
      rst = 1'b1;
      write_req_valid = 1'b0; write_start_address = '0; write_byte_count = '0;
      write_data_valid = 1'b0; write_data = '0; write_resp_ready = 1'b0;
      axi_awready = 1'b0; axi_wready = 1'b0; axi_bid = 4'd0; axi_bresp = 2'b00;
      axi_bvalid = 1'b0;

      // Reset state
      repeat (2) @(negedge core_clk);
      #1;
      check("rst_req_ready", write_req_ready, 1'b1);
      check("rst_awvalid", axi_awvalid, 1'b0);
      check("rst_wvalid", axi_wvalid, 1'b0);
      check("rst_bready", axi_bready, 1'b0);
      check("rst_resp_valid", write_resp_valid, 1'b0);
      rst = 1'b0;

      // Single beat burst: 64 bytes at 0x1000
      send_req(34'h1000, 64);
      aw_phase(34'h1000, 8'd0, 0);
      w_phase(0, 1, 0, ALL, 0);
      b_phase(2'b00, 0);
      resp_phase(1'b0);

      // 4100 bytes: 64 full beats, then one 4-byte beat at 0x1000
      send_req(34'h0, 4100);
      aw_phase(34'h0, 8'd63, 0);
      w_phase(63, 64, 0, ALL, 0);
      b_phase(2'b00, 0);
      aw_phase(34'h1000, 8'd0, 0);
      w_phase(0, 1, 64, 64'hF, 0);
      b_phase(2'b00, 0);
      resp_phase(1'b0);

      // 8192 bytes: two full bursts, 128 handshakes in total
      hs0 = hs_count;
      send_req(34'h0, 8192);
      aw_phase(34'h0, 8'd63, 0);
      w_phase(63, 64, 0, ALL, 0);
      b_phase(2'b00, 0);
      aw_phase(34'h1000, 8'd63, 0);
      w_phase(63, 64, 64, ALL, 0);
      b_phase(2'b00, 0);
      resp_phase(1'b0);
      check("hs_8192", hs_count - hs0, 128);

      // 200 bytes with stalls on every channel: 4 beats, last strobe 0xFF
      hs0 = hs_count;
      send_req(34'h3000, 200);
      aw_phase(34'h3000, 8'd3, 2);
      w_phase(3, 4, 0, 64'hFF, 1);
      b_phase(2'b00, 2);
      resp_phase(1'b0);
      check("hs_200", hs_count - hs0, 4);

      // SLVERR on the first burst only: sticky error, then a clean request
      send_req(34'h0, 8192);
      aw_phase(34'h0, 8'd63, 0);
      w_phase(63, 64, 0, ALL, 0);
      b_phase(2'b10, 0);
      aw_phase(34'h1000, 8'd63, 0);
      w_phase(63, 64, 64, ALL, 0);
      b_phase(2'b00, 0);
      resp_phase(1'b1);
      send_req(34'h1000, 64);
      aw_phase(34'h1000, 8'd0, 0);
      w_phase(0, 1, 0, ALL, 0);
      b_phase(2'b00, 0);
      resp_phase(1'b0);

      // Zero byte count: straight to completion, no AW
      send_req(34'h2000, 0);
      resp_phase(1'b0);

      // Reset in the middle of the first burst of a 3-burst request
      send_req(34'h0, 12288);
      aw_phase(34'h0, 8'd63, 0);
      w_phase(63, 3, 0, ALL, 0);
      @(negedge core_clk);
      write_data_valid = 1'b1;
      write_data       = pat(3);
      axi_wready       = 1'b1;
      #1 check("pre_rst_wvalid", axi_wvalid, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("async_wvalid", axi_wvalid, 1'b0);
      check("async_dready", write_data_ready, 1'b0);
      check("async_awvalid", axi_awvalid, 1'b0);
      check("async_bready", axi_bready, 1'b0);
      check("async_resp", write_resp_valid, 1'b0);
      check("async_req_ready", write_req_ready, 1'b1);
      @(negedge core_clk);
      rst = 1'b0;
      write_data_valid = 1'b0;
      send_req(34'h5000, 64);
      aw_phase(34'h5000, 8'd0, 0);
      w_phase(0, 1, 0, ALL, 0);
      b_phase(2'b00, 0);
      resp_phase(1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/axi_write_master.md
Name: axi_write_master

Overview:
- AXI4 write-channel initiator, companion to the read-side fetch master: the counterpart that pushes 512b data out to memory.
- Accepts a write request (start address, byte count) and a 512b data beat stream.
- Splits the request into INCR bursts of up to 64 beats x 64 bytes, so no burst crosses a 4 KB boundary.
- Drives AW/W, collects B responses, and returns a single completion with an aggregated error flag.

Parameters:
- MAX_BYTE_COUNT, 1000000000, largest byte count per request; BC_W = $clog2(MAX_BYTE_COUNT).
- AXI_ADDRESS_WIDTH, 34, AXI address width.
- DATA_WIDTH, 512, data bus width; fixed at 512 (64 bytes/beat).

Ports:
- core_clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- write_req_valid  in  1  request valid.
- write_req_ready  out  1  request ready, high only in IDLE.
- write_start_address  in  AXI_ADDRESS_WIDTH  start address; bits [11:0] must be 0.
- write_byte_count  in  BC_W  bytes to write.
- write_data_valid  in  1  data beat valid.
- write_data_ready  out  1  data beat ready.
- write_data  in  DATA_WIDTH  data beat.
- write_resp_valid  out  1  request complete.
- write_resp_ready  in  1  completion accept.
- write_resp_error  out  1  at least one BRESP != OKAY during the request.
- axi_awaddr  out  AXI_ADDRESS_WIDTH.
- axi_awburst  out  2.
- axi_awcache  out  4.
- axi_awid  out  4.
- axi_awlen  out  8.
- axi_awlock  out  1.
- axi_awprot  out  3.
- axi_awqos  out  4.
- axi_awsize  out  3.
- axi_awvalid  out  1.
- axi_awready  in  1.
- axi_wdata  out  DATA_WIDTH.
- axi_wstrb  out  DATA_WIDTH/8.
- axi_wlast  out  1.
- axi_wvalid  out  1.
- axi_wready  in  1.
- axi_bid  in  4.
- axi_bresp  in  2.
- axi_bvalid  in  1.
- axi_bready  out  1.

Behaviour:
- Reset, effective immediately on rst:
  - State IDLE; all counters and address 0; error flag 0.
  - All valid outputs 0 and axi_bready 0; write_req_ready 1 once in IDLE.
- Reset mid-operation abandons the transfer; no AXI channel recovery is attempted.
- Request capture: on write_req_valid && write_req_ready, latch address and count.
  - total_beats = ceil(count/64); tail = count[5:0]; bursts = ceil(total_beats/64); final_len = total_beats mod 64, where 0 means 64.
  - count == 0: go directly to RESP with error 0 and no AXI activity.
- FSM: IDLE -> AW -> W -> B -> (AW if bursts remain, else RESP) -> IDLE.
- AW state:
  - axi_awvalid = 1; awaddr = current address; awlen = 63, or final_len-1 for the last burst.
  - awburst = 2'b01 (INCR); awsize = 3'b110; awid = 0; cache/lock/prot/qos = 0.
  - Outputs hold stable until axi_awready; then go to W with beat_in_burst = 0.
- W state: pure combinational pass-through, no data buffering.
  - axi_wvalid = write_data_valid; write_data_ready = axi_wready; axi_wdata = write_data.
  - axi_wlast = 1 when beat_in_burst == awlen.
  - axi_wstrb: all ones, except on the overall final beat with tail != 0, where only the low tail bits are set (e.g. tail=5 -> 0x1F).
  - On each handshake, beat_in_burst increments; on the wlast handshake go to B.
  - No W beat is issued before its AW handshake.
- B state:
  - axi_bready = 1.
  - On axi_bvalid: error |= (axi_bresp != 2'b00); address += 4096; burst counter increments.
  - Then go to AW if bursts remain, else RESP.
  - axi_bid is ignored, since all IDs are 0.
- RESP state:
  - write_resp_valid = 1; write_resp_error = sticky flag, both held until write_resp_ready.
  - Then go to IDLE and clear all counters and the flag.
- Only one burst is outstanding at a time; there is no AW/W overlap across bursts.
- write_data_ready and axi_wvalid are 0 outside the W state.
- Beats supplied by the producer beyond total_beats are not consumed.
- Counters: burst counter $clog2(MAX_TRANSACTIONS)+1 bits, beat counter 8 bits, address wraps modulo 2^AXI_ADDRESS_WIDTH.

Test Plan:
- Request addr=0x1000, count=64 -> one AW (awlen=0, awaddr=0x1000), one W with wlast=1 and wstrb all ones, B OKAY -> resp_valid with error=0.
- count=4100, addr=0x0 -> AW0 len=63 @0x0 and 64 beats; then AW1 len=0 @0x1000 and 1 beat with wstrb=0xF; single completion.
- count=8192 -> two bursts, each len=63, addresses 0x0 and 0x1000; exactly 128 W handshakes; wlast on beats 64 and 128.
- Random stalls on awready/wready/data_valid/bvalid with count=200 (awlen=3, final wstrb=0xFF) -> AW/W signals stable under stall; data order preserved; no beat lost or duplicated.
- Burst 1 BRESP=SLVERR, burst 2 OKAY -> write_resp_error=1; second request afterwards completes with error=0.
- Assert rst during the W state of a 3-burst request -> outputs clear asynchronously; new request after reset starts at AW with awaddr = new address.
